// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V pipeline front end.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_debug_fsm.sv
// Debug run/halt/single-step control for the fetch stage; decides when IF may advance.
module fetch_debug_fsm
  import riscv_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_debug_halt,
  input  logic i_debug_step,
  input  logic i_stall,
  input  logic i_redirect_valid,
  output logic o_advance_en,
  output logic o_halted,
  output logic o_step_done
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         r_step_done;
  logic         w_step_done_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_step_done <= w_step_done_next;
    end
  end

  // A redirect freezes the FSM except in STEP, where it consumes the step.
  always_comb begin
    w_state_next     = r_state;
    o_advance_en     = 1'b0;
    w_step_done_next = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (!i_redirect_valid) begin
          if (i_debug_halt) w_state_next = ST_HALTED;
          else              o_advance_en = !i_stall;
        end
      end
      ST_HALTED: begin
        if (!i_redirect_valid) begin
          if (i_debug_step)      w_state_next = ST_STEP;
          else if (!i_debug_halt) w_state_next = ST_RUN;
        end
      end
      ST_STEP: begin
        if (i_redirect_valid || !i_stall) begin
          o_advance_en     = !i_redirect_valid;
          w_step_done_next = 1'b1;
          w_state_next     = ST_HALTED;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign o_halted    = (r_state == ST_HALTED);
  assign o_step_done = r_step_done;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch with PC register, IF/ID pipeline register, stall/flush and debug stepping.
module if_id_fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int unsigned          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  input  logic                 debug_halt,
  input  logic                 debug_step,
  output logic [PC_WIDTH-1:0]  if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid,
  output logic [4:0]           if_id_rs1,
  output logic [4:0]           if_id_rs2,
  output logic                 halted,
  output logic                 step_done,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  r_if_id_pc;
  logic [31:0]          r_if_id_instr;
  logic                 r_if_id_valid;
  logic [CNT_WIDTH-1:0] r_fetch_count;
  logic                 w_advance;

  fetch_debug_fsm u_fsm (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_debug_halt     (debug_halt),
    .i_debug_step     (debug_step),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .o_advance_en     (w_advance),
    .o_halted         (halted),
    .o_step_done      (step_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else if (redirect_valid) begin
      r_pc          <= {redirect_target[PC_WIDTH-1:2], 2'b00};
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (w_advance) begin
      r_pc          <= r_pc + PC_WIDTH'(4);
      r_if_id_pc    <= r_pc;
      r_if_id_instr <= imem_rdata;
      r_if_id_valid <= 1'b1;
      r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign if_id_rs1   = r_if_id_instr[RS1_MSB:RS1_LSB];
  assign if_id_rs2   = r_if_id_instr[RS2_MSB:RS2_LSB];
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Randomized bench for if_id_fetch_stage against a behavioural fetch model.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        debug_halt;
  logic        debug_step;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        halted;
  logic        step_done;
  logic [31:0] fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_halted, m_stepping, m_sd;

  always #5 clk = ~clk;

  if_id_fetch_stage #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_WIDTH (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .debug_halt      (debug_halt),
    .debug_step      (debug_step),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .halted          (halted),
    .step_done       (step_done),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_8113;
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign imem_rdata = imem(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_cnt = 32'h0; m_halted = 1'b0; m_stepping = 1'b0; m_sd = 1'b0;
  endtask

  // Drive one cycle of inputs, compare all outputs against the model, then step the model.
  task automatic cycle(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rt, input logic dh, input logic ds);
    logic adv;
    logic sd_n;
    reset = rst; stall = st; redirect_valid = rv; redirect_target = rt;
    debug_halt = dh; debug_step = ds;
    @(negedge clk);
    check("imem_addr",   imem_addr,   m_pc);
    check("if_id_pc",    if_id_pc,    m_ipc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check("if_id_rs1",   {27'b0, if_id_rs1}, {27'b0, m_instr[19:15]});
    check("if_id_rs2",   {27'b0, if_id_rs2}, {27'b0, m_instr[24:20]});
    check("halted",      {31'b0, halted},    {31'b0, m_halted});
    check("step_done",   {31'b0, step_done}, {31'b0, m_sd});
    check("fetch_count", fetch_count, m_cnt);
    adv = 1'b0;
    sd_n = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (rv) begin
        m_pc = {rt[31:2], 2'b00}; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
        if (m_stepping) begin m_stepping = 1'b0; m_halted = 1'b1; sd_n = 1'b1; end
      end else if (m_stepping) begin
        if (!st) begin adv = 1'b1; m_stepping = 1'b0; m_halted = 1'b1; sd_n = 1'b1; end
      end else if (m_halted) begin
        if (ds) begin m_halted = 1'b0; m_stepping = 1'b1; end
        else if (!dh) m_halted = 1'b0;
      end else begin
        if (dh) m_halted = 1'b1;
        else if (!st) adv = 1'b1;
      end
      if (adv) begin
        m_ipc = m_pc; m_instr = imem(m_pc); m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
      end
      m_sd = sd_n;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r_halt_lvl;
    logic [31:0] tgt;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    debug_halt = 1'b0; debug_step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(1, 0, 0, 0, 0, 0);

    // Two free cycles from reset
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("boot_pc",    if_id_pc,    32'h4);
    check("boot_instr", if_id_instr, 32'h0010_8113);
    check("boot_valid", {31'b0, if_id_valid}, 32'h1);
    check("boot_cnt",   fetch_count, 32'd2);
    check("boot_addr",  imem_addr,   32'h8);

    // Stall holds, release advances
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_ifpc", if_id_pc,  32'h4);
    cycle(0, 0, 0, 0, 0, 0);
    check("rel_ifpc", if_id_pc,  32'h8);
    check("rel_addr", imem_addr, 32'hC);

    // Redirect during stall flushes and aligns the target
    cycle(0, 1, 1, 32'h103, 0, 0);
    check("redir_addr",  imem_addr,   32'h100);
    check("redir_instr", if_id_instr, NOP);
    check("redir_valid", {31'b0, if_id_valid}, 32'h0);
    check("redir_rs1",   {27'b0, if_id_rs1}, 32'h0);
    check("redir_cnt",   fetch_count, 32'd3);

    // Halt, single step, resume
    cycle(0, 0, 1, 32'h10, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_addr", imem_addr, 32'h10);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("step_addr", imem_addr, 32'h14);
    check("step_done", {31'b0, step_done}, 32'h1);
    check("step_halt", {31'b0, halted}, 32'h1);
    cycle(0, 0, 0, 0, 1, 0);
    check("step_pulse", {31'b0, step_done}, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    check("resume_addr", imem_addr, 32'h14);
    cycle(0, 0, 0, 0, 0, 0);
    check("resume_adv", imem_addr, 32'h18);

    // Step held off by stall
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);
    repeat (2) cycle(0, 1, 0, 0, 1, 0);
    check("stall_step_sd", {31'b0, step_done}, 32'h0);
    check("stall_step_pc", imem_addr, 32'h18);
    cycle(0, 0, 0, 0, 1, 0);
    check("stall_step_done", {31'b0, step_done}, 32'h1);
    check("stall_step_adv",  imem_addr, 32'h1C);

    // Reset in the middle of a step
    cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 1, 0, 0, 1, 0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_halt",  {31'b0, halted}, 32'h0);
    check("rst_cnt",   fetch_count, 32'h0);
    check("rst_instr", if_id_instr, NOP);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_ifpc", if_id_pc,  32'hFFFF_FFFC);

    // Random traffic
    r_halt_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) r_halt_lvl = ~r_halt_lvl;
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0),
            tgt,
            r_halt_lvl,
            ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
